// File: rtl/dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// dma_priority_arbiter
//
// Purpose:
//   Priority / hold-request sequencer for the DMA controller. It picks one
//   requesting channel, runs the HRQ/HLDA handshake with the host, and then
//   holds a one-hot DACK for that channel until timing/control reports the
//   end of service. The winning channel index goes to the datapath.
//
// Configuration:
//   ROTATING_PRIORITY_EN  when defined, the channel just served becomes the
//                         lowest priority after a normal end of service.
//                         When undefined, priority is fixed (channel 0 is
//                         highest, CHANNELS-1 is lowest).
//
// Ports:
//   CLK          in   1         system clock, rising edge
//   RESET        in   1         synchronous, active-high reset
//   DREQ         in   CHANNELS  channel requests, level-sensitive
//   HLDA         in   1         hold acknowledge from host CPU
//   MASK         in   CHANNELS  per-channel mask, 1 = channel ignored
//   CMD_DISABLE  in   1         blocks new arbitration
//   SVC_END      in   1         one-cycle pulse, current service finished
//   HRQ          out  1         hold request to host
//   DACK         out  CHANNELS  one-hot channel acknowledge
//   GRANT_VALID  out  1         high while DACK is asserted
//   GRANT_CH     out  CHW       index of the locked winner
//   ABORT        out  1         one-cycle pulse, HLDA lost during service
// -----------------------------------------------------------------------------
module dma_priority_arbiter #(
  parameter int CHANNELS = 4,
  localparam int CHW = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] DREQ,
  input  logic                HLDA,
  input  logic [CHANNELS-1:0] MASK,
  input  logic                CMD_DISABLE,
  input  logic                SVC_END,
  output logic                HRQ,
  output logic [CHANNELS-1:0] DACK,
  output logic                GRANT_VALID,
  output logic [CHW-1:0]      GRANT_CH,
  output logic                ABORT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [CHW-1:0]      ptr_r;
  logic [CHW-1:0]      ptr_next_s;
  logic [CHW-1:0]      ptr_svc_s;
  logic [CHW-1:0]      grant_ch_r;
  logic [CHW-1:0]      grant_ch_next_s;
  logic                hrq_r;
  logic                hrq_next_s;
  logic [CHANNELS-1:0] dack_r;
  logic [CHANNELS-1:0] dack_next_s;
  logic                grant_valid_r;
  logic                grant_valid_next_s;
  logic                abort_r;
  logic                abort_next_s;
  logic [CHANNELS-1:0] ereq_s;
  logic [CHW:0]        win_s;

  // Round-robin style scan starting at ptr; returns {found, index}.
  // Scanning from the farthest offset down lets the nearest hit overwrite.
  function automatic logic [CHW:0] pick_winner(input logic [CHANNELS-1:0] req,
                                               input logic [CHW-1:0]      ptr);
    logic [CHW:0]   result;
    logic [CHW-1:0] idx;
    result = {(CHW+1){1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = ptr + CHW'(i);
      if (req[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  assign ereq_s = CMD_DISABLE ? {CHANNELS{1'b0}} : (DREQ & ~MASK);
  assign win_s  = pick_winner(ereq_s, ptr_r);

`ifdef ROTATING_PRIORITY_EN
  // Served channel drops to lowest priority; index width wraps modulo CHANNELS.
  assign ptr_svc_s = grant_ch_r + CHW'(1'b1);
`else
  assign ptr_svc_s = {CHW{1'b0}};
`endif

  // State and registered outputs; synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      ptr_r         <= {CHW{1'b0}};
      grant_ch_r    <= {CHW{1'b0}};
      hrq_r         <= 1'b0;
      dack_r        <= {CHANNELS{1'b0}};
      grant_valid_r <= 1'b0;
      abort_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      ptr_r         <= ptr_next_s;
      grant_ch_r    <= grant_ch_next_s;
      hrq_r         <= hrq_next_s;
      dack_r        <= dack_next_s;
      grant_valid_r <= grant_valid_next_s;
      abort_r       <= abort_next_s;
    end
  end

  // Next-state and next-output decode for the handshake sequencer.
  always_comb begin
    state_next_s       = state_r;
    ptr_next_s         = ptr_r;
    grant_ch_next_s    = grant_ch_r;
    hrq_next_s         = hrq_r;
    dack_next_s        = dack_r;
    grant_valid_next_s = grant_valid_r;
    abort_next_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Spurious HLDA here is ignored: nothing reacts to it.
        dack_next_s        = {CHANNELS{1'b0}};
        grant_valid_next_s = 1'b0;
        if (win_s[CHW]) begin
          grant_ch_next_s = win_s[CHW-1:0];
          hrq_next_s      = 1'b1;
          state_next_s    = ST_REQ;
        end else begin
          hrq_next_s      = 1'b0;
          state_next_s    = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Winner stays locked; withdrawal is judged on the raw request line.
        if (HLDA) begin
          dack_next_s        = {{(CHANNELS-1){1'b0}}, 1'b1} << grant_ch_r;
          grant_valid_next_s = 1'b1;
          state_next_s       = ST_GRANT;
        end else if (!DREQ[grant_ch_r]) begin
          hrq_next_s         = 1'b0;
          state_next_s       = ST_IDLE;
        end else begin
          state_next_s       = ST_REQ;
        end
      end

      ST_GRANT: begin
        // SVC_END wins over a simultaneous HLDA drop: treated as a normal end.
        if (SVC_END) begin
          dack_next_s        = {CHANNELS{1'b0}};
          grant_valid_next_s = 1'b0;
          hrq_next_s         = 1'b0;
          ptr_next_s         = ptr_svc_s;
          state_next_s       = ST_RELEASE;
        end else if (!HLDA) begin
          dack_next_s        = {CHANNELS{1'b0}};
          grant_valid_next_s = 1'b0;
          hrq_next_s         = 1'b0;
          abort_next_s       = 1'b1;
          state_next_s       = ST_RELEASE;
        end else begin
          state_next_s       = ST_GRANT;
        end
      end

      ST_RELEASE: begin
        // No new request until the host has visibly dropped HLDA.
        hrq_next_s = 1'b0;
        if (!HLDA) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RELEASE;
        end
      end

      default: begin
        state_next_s       = ST_IDLE;
        hrq_next_s         = 1'b0;
        dack_next_s        = {CHANNELS{1'b0}};
        grant_valid_next_s = 1'b0;
      end
    endcase
  end

  assign HRQ         = hrq_r;
  assign DACK        = dack_r;
  assign GRANT_VALID = grant_valid_r;
  assign GRANT_CH    = grant_ch_r;
  assign ABORT       = abort_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_priority_arbiter
//
// Directed scenarios followed by a randomized run. A behavioural model of the
// arbiter (phase flags, integer channel/pointer arithmetic) predicts every
// output after each rising edge; selected scenario points are also checked
// against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_dma_priority_arbiter;

  localparam int N = 4;
`ifdef ROTATING_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] dreq;
  logic         hlda;
  logic [N-1:0] mask;
  logic         cmd_dis;
  logic         svc_end;
  logic         hrq;
  logic [N-1:0] dack;
  logic         gvalid;
  logic [1:0]   gch;
  logic         abort;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit         m_hrq, m_gv, m_abort;
  logic [3:0] m_dack;
  int         m_ch, m_ptr;
  bit         m_locked, m_serving, m_wait_drop;

  dma_priority_arbiter #(.CHANNELS(N)) dut (
    .CLK(clk), .RESET(rst), .DREQ(dreq), .HLDA(hlda), .MASK(mask),
    .CMD_DISABLE(cmd_dis), .SVC_END(svc_end), .HRQ(hrq), .DACK(dack),
    .GRANT_VALID(gvalid), .GRANT_CH(gch), .ABORT(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    logic [3:0] ereq;
    int c;
    m_abort = 1'b0;
    if (rst) begin
      m_hrq = 0; m_gv = 0; m_dack = 4'b0000; m_ch = 0; m_ptr = 0;
      m_locked = 0; m_serving = 0; m_wait_drop = 0;
    end else if (m_wait_drop) begin
      if (!hlda) m_wait_drop = 0;
    end else if (m_serving) begin
      if (svc_end || !hlda) begin
        m_abort     = !svc_end;
        m_serving   = 0;
        m_wait_drop = 1;
        m_dack      = 4'b0000;
        m_gv        = 0;
        m_hrq       = 0;
        if (svc_end && ROT) m_ptr = (m_ch + 1) % N;
      end
    end else if (m_locked) begin
      if (hlda) begin
        m_locked  = 0;
        m_serving = 1;
        m_dack    = 4'b0001 << m_ch;
        m_gv      = 1;
      end else if (!dreq[m_ch]) begin
        m_locked = 0;
        m_hrq    = 0;
      end
    end else begin
      ereq = cmd_dis ? 4'b0000 : (dreq & ~mask);
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (ereq[c]) begin
          m_ch = c; m_locked = 1; m_hrq = 1;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("hrq", {31'd0, hrq}, {31'd0, m_hrq});
    check("dack", {28'd0, dack}, {28'd0, m_dack});
    check("grant_valid", {31'd0, gvalid}, {31'd0, m_gv});
    check("grant_ch", {30'd0, gch}, m_ch);
    check("abort", {31'd0, abort}, {31'd0, m_abort});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From IDLE with requests applied: request, grant, finish, release.
  task automatic serve(input int exp_ch, input string tag);
    tick();
    check({tag, "_ch"}, {30'd0, gch}, exp_ch);
    hlda = 1'b1;
    tick();
    check({tag, "_dack"}, {28'd0, dack}, 32'd1 << exp_ch);
    svc_end = 1'b1;
    tick();
    svc_end = 1'b0;
    hlda = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; dreq = 4'b0000; hlda = 1'b0; mask = 4'b0000;
    cmd_dis = 1'b0; svc_end = 1'b0;
    tick();
    tick();
    check("rst_hrq", {31'd0, hrq}, 32'd0);
    check("rst_dack", {28'd0, dack}, 32'd0);
    check("rst_gch", {30'd0, gch}, 32'd0);
    rst = 1'b0;

    // 1: single request, host answers two cycles after HRQ
    dreq = 4'b0100;
    tick();
    check("t1_hrq", {31'd0, hrq}, 32'd1);
    check("t1_gch", {30'd0, gch}, 32'd2);
    tick();
    check("t1_no_dack_yet", {28'd0, dack}, 32'd0);
    hlda = 1'b1;
    tick();
    check("t1_dack", {28'd0, dack}, 32'h4);
    check("t1_gvalid", {31'd0, gvalid}, 32'd1);
    svc_end = 1'b1;
    tick();
    svc_end = 1'b0; hlda = 1'b0; dreq = 4'b0000;
    tick();
    tick();

    // 2: two contenders held; fixed vs rotating order
    do_reset();
    dreq = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      serve(ROT ? ((i % 2 == 0) ? 1 : 3) : 1, "t2");
    end
    dreq = 4'b0000;
    tick();
    tick();

    // 3: mask and controller-disable block arbitration
    do_reset();
    dreq = 4'b0001; mask = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_masked", {31'd0, hrq}, 32'd0);
    end
    mask = 4'b0000;
    tick();
    check("t3_unmasked", {31'd0, hrq}, 32'd1);
    dreq = 4'b0000;
    tick();
    cmd_dis = 1'b1; dreq = 4'b0001;
    tick();
    tick();
    check("t3_disabled", {31'd0, hrq}, 32'd0);
    cmd_dis = 1'b0;
    tick();
    check("t3_enabled", {31'd0, hrq}, 32'd1);
    dreq = 4'b0000;
    tick();

    // 4: locked winner withdraws, then re-arbitrate
    do_reset();
    dreq = 4'b0001;
    tick();
    check("t4_gch0", {30'd0, gch}, 32'd0);
    dreq = 4'b1000;
    tick();
    check("t4_withdrawn", {31'd0, hrq}, 32'd0);
    tick();
    check("t4_rearb_hrq", {31'd0, hrq}, 32'd1);
    check("t4_rearb_ch", {30'd0, gch}, 32'd3);
    dreq = 4'b0000;
    tick();

    // 5: HLDA lost mid-service
    do_reset();
    dreq = 4'b0100;
    tick();
    hlda = 1'b1;
    tick();
    check("t5_dack", {28'd0, dack}, 32'h4);
    hlda = 1'b0;
    dreq = 4'b1100;
    tick();
    check("t5_abort", {31'd0, abort}, 32'd1);
    check("t5_dack_off", {28'd0, dack}, 32'd0);
    check("t5_hrq_off", {31'd0, hrq}, 32'd0);
    hlda = 1'b1;
    tick();
    check("t5_abort_once", {31'd0, abort}, 32'd0);
    tick();
    check("t5_wait_hlda", {31'd0, hrq}, 32'd0);
    hlda = 1'b0;
    tick();
    check("t5_idle_hrq", {31'd0, hrq}, 32'd0);
    tick();
    check("t5_rereq", {31'd0, hrq}, 32'd1);
    check("t5_ptr_kept", {30'd0, gch}, 32'd2);
    dreq = 4'b0000;
    tick();

    // 6: reset during grant
    do_reset();
    dreq = 4'b0010;
    tick();
    hlda = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("t6_hrq", {31'd0, hrq}, 32'd0);
    check("t6_dack", {28'd0, dack}, 32'd0);
    check("t6_gvalid", {31'd0, gvalid}, 32'd0);
    check("t6_gch", {30'd0, gch}, 32'd0);
    rst = 1'b0; hlda = 1'b0;
    tick();
    check("t6_rereq", {31'd0, hrq}, 32'd1);
    dreq = 4'b0000;
    tick();

    // Spurious HLDA while idle
    hlda = 1'b1;
    tick();
    tick();
    check("spur_dack", {28'd0, dack}, 32'd0);
    check("spur_hrq", {31'd0, hrq}, 32'd0);
    hlda = 1'b0;
    tick();

    // Randomized traffic with a loosely behaved host
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) dreq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cmd_dis = ($urandom_range(0, 19) == 0);
      svc_end = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      if (m_hrq) hlda = ($urandom_range(0, 5) != 0);
      else       hlda = hlda ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
